// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default byte-to-word address shift.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int ADDR_LSB_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        MERGE,
        WRITE,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for a 4-lane little-endian word:
// load extraction with sign/zero extension, store merge, and alignment check.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge,
    output logic        o_misaligned
);

    logic [4:0]  w_shamt;
    logic [15:0] w_lane;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    // Select the addressed lane(s), build the lane mask and flag bad alignment
    always_comb begin
        w_shamt      = {i_off, 3'b000};
        w_lane       = 16'(i_word >> w_shamt);
        w_mask       = 32'h0000_0000;
        o_extract    = 32'h0000_0000;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                w_mask    = 32'h0000_00FF << w_shamt;
                o_extract = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
            end
            SZ_HALF: begin
                w_mask       = 32'h0000_FFFF << w_shamt;
                o_extract    = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
                o_misaligned = i_off[0];
            end
            SZ_WORD: begin
                w_mask       = 32'hFFFF_FFFF;
                o_extract    = i_word;
                o_misaligned = (i_off != 2'b00);
            end
            default: o_misaligned = 1'b1;
        endcase
        // Store data is right-justified; shift it into the addressed lane(s)
        w_ins   = i_data << w_shamt;
        o_merge = (i_word & ~w_mask) | (w_ins & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer. Issues word-wide accesses to dataMemory,
// performs sub-word stores by read-modify-write and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int IN_BUS_WIDTH = 32,
    parameter int MEMORY_WIDTH = 32,
    parameter int ADDR_LSB     = ADDR_LSB_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    reqWrite,
    input  logic [1:0]              reqSize,
    input  logic                    reqSigned,
    input  logic [IN_BUS_WIDTH-1:0] ALUMemAdd,
    input  logic [MEMORY_WIDTH-1:0] writeDataM,
    output logic                    respValid,
    output logic                    respErr,
    output logic [MEMORY_WIDTH-1:0] loadDataW,
    output logic                    busy,
    output logic                    memWriteEn,
    output logic                    memReadEn,
    output logic [IN_BUS_WIDTH-1:0] memAdd,
    output logic [MEMORY_WIDTH-1:0] memWriteData,
    input  logic [MEMORY_WIDTH-1:0] memReadData
);

    lsu_state_t r_state;
    lsu_state_t w_next;

    logic                    r_write;
    logic [1:0]              r_size;
    logic [1:0]              r_off;
    logic                    r_signed;
    logic [MEMORY_WIDTH-1:0] r_wdata;

    logic                    w_accept;
    logic [1:0]              w_off;
    logic [1:0]              w_size;
    logic                    w_misaligned;
    logic [MEMORY_WIDTH-1:0] w_extract;
    logic [MEMORY_WIDTH-1:0] w_merge;

    assign reqReady = (r_state == IDLE) && !RST;
    assign busy     = (r_state != IDLE);
    assign w_accept = reqValid && reqReady;

    // In IDLE the lane logic sees the incoming request (alignment check);
    // afterwards it sees the latched request (extract/merge).
    assign w_off  = (r_state == IDLE) ? ALUMemAdd[1:0] : r_off;
    assign w_size = (r_state == IDLE) ? reqSize : r_size;

    lsu_lane_align u_align (
        .i_word      (memReadData),
        .i_data      (r_wdata),
        .i_off       (w_off),
        .i_size      (w_size),
        .i_signed    (r_signed),
        .o_extract   (w_extract),
        .o_merge     (w_merge),
        .o_misaligned(w_misaligned)
    );

    // Next-state selection for the access sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misaligned)
                        w_next = RESP;
                    else if (reqWrite && (reqSize == SZ_WORD))
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            READ:    w_next = r_write ? MERGE : CAPTURE;
            CAPTURE: w_next = RESP;
            MERGE:   w_next = WRITE;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register and registered memory/response outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            respValid    <= 1'b0;
            respErr      <= 1'b0;
            memReadEn    <= 1'b0;
            memWriteEn   <= 1'b0;
            loadDataW    <= '0;
            memAdd       <= '0;
            memWriteData <= '0;
        end else begin
            r_state    <= w_next;
            memReadEn  <= (w_next == READ);
            memWriteEn <= (w_next == WRITE);
            respValid  <= (w_next == RESP);
            // IDLE jumps straight to RESP only for a rejected request
            respErr    <= (r_state == IDLE) && (w_next == RESP);
            loadDataW  <= (r_state == CAPTURE) ? w_extract : '0;
            if (w_accept)
                memAdd <= ALUMemAdd >> ADDR_LSB;
            if (w_accept && (w_next == WRITE))
                memWriteData <= writeDataM;
            else if (r_state == MERGE)
                memWriteData <= w_merge;
        end
    end

    // Request fields captured at acceptance
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_write  <= reqWrite;
            r_size   <= reqSize;
            r_off    <= ALUMemAdd[1:0];
            r_signed <= reqSigned;
            r_wdata  <= writeDataM;
        end
    end

endmodule
